// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle sequencer driving datapath selects, enables and the memory port
// Latency: FETCH/DECODE plus 1-3 more states (3-5 cycles) with zero-wait memory, +1 cycle per memory wait
// Backpressure: mem_req and address held until mem_ready; optional wait timeout traps to a sticky illegal state
module multicycle_control #(
    parameter int ALUCTRL_W   = 3,
    parameter int MEM_EN      = 1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [2:0]           imm_src,
    output logic [1:0]           result_src,
    output logic                 illegal,
    output logic [3:0]           state
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] LUI      = 4'd11;
    localparam logic [3:0] TRAP     = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] decode_next;
    logic [7:0] wait_cnt;
    logic       illegal_q;
    logic       mem_state;
    logic       stalled;
    logic       timed_out;
    logic       alu_sub;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register and immediate fields belong to the datapath, not the sequencer.
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    // A memory access is outstanding in these states; mem_ready is ignored elsewhere.
    assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign stalled   = mem_state && !mem_ready;
    // Completion on the timeout cycle wins over the trap because stalled requires mem_ready = 0.
    assign timed_out = (TIMEOUT != 8'd0) && stalled && (wait_cnt == TIMEOUT);

    // Dispatch from DECODE: only the supported RV32I subset leaves the trap path.
    always_comb begin
        decode_next = TRAP;
        case (opcode)
            OP_R:      if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))
                           decode_next = EXECR;
            OP_IMM:    if (funct3 == 3'b000) decode_next = EXECI;
            OP_LOAD,
            OP_STORE:  if (MEM_EN != 0 && funct3 == 3'b010) decode_next = MEMADR;
            OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) decode_next = BRANCH;
            OP_JAL:    decode_next = JAL;
            OP_LUI:    decode_next = LUI;
            default:   decode_next = TRAP;
        endcase
    end

    // Next-state sequencing; a memory timeout overrides every wait state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE:   state_d = decode_next;
            MEMADR:   state_d = opcode[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            MEMWB, ALUWB, BRANCH, LUI: state_d = FETCH;
            EXECR, EXECI, JAL:         state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = TRAP;
        endcase
        if (timed_out) state_d = TRAP;
    end

    // State, saturating wait counter (cleared on any state change) and sticky illegal flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_cnt  <= 8'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) wait_cnt <= 8'd0;
            else if (stalled && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    // Datapath controls per state; reset forces everything low without waiting for a clock.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_sub    = 1'b0;
        imm_src    = 3'b000;
        result_src = 2'b00;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
                end
                EXECR: begin
                    alu_src_a = 2'b10;
                    alu_sub   = funct7[5];
                end
                EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = opcode[5] ? 3'b001 : 3'b000;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                end
                MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                ALUWB: reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_sub   = 1'b1;
                    pc_write  = funct3[0] ? ~zero : zero;
                end
                JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                LUI: begin
                    imm_src    = 3'b100;
                    result_src = 2'b11;
                    reg_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_ctrl = ALUCTRL_W'(alu_sub);
    assign illegal  = illegal_q & ~rst;
    assign state    = rst ? FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: two DUT streams (memory on with 4-cycle timeout, memory off with no timeout)
// Driver pushes expected per-cycle outputs from an instruction-level reference model into queues
// Monitor pops and compares on the falling edge, independent of the driver
module tb_multicycle_control;
    localparam int T0 = 4;

    // State numbering follows the order the states are listed in the design description.
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
    localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;
    localparam int S_JAL = 10, S_LUI = 11, S_TRAP = 12;

    localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_JAL = 7, K_LUI = 8, K_ILL = 9;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic       illegal;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        logic [31:0] ins;
        int          fw;      // fetch wait cycles
        int          mw;      // data access wait cycles
        bit          z;       // ALU zero flag for branches
        int          rst_at;  // cycle within instruction to assert reset, -1 = none
    } item_t;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  zero = 2'b00;
    logic [1:0]  mem_ready = 2'b00;
    logic [31:0] instr [2];
    obs_t        act [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
        logic [1:0] alu_src_a, alu_src_b, result_src;
        logic [2:0] alu_ctrl, imm_src;
        logic [3:0] state;

        multicycle_control #(
            .ALUCTRL_W  (3),
            .MEM_EN     ((g == 0) ? 1 : 0),
            .MEM_TIMEOUT((g == 0) ? T0 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .instr     (instr[g]),
            .zero      (zero[g]),
            .mem_ready (mem_ready[g]),
            .mem_req   (mem_req),
            .mem_we    (mem_we),
            .adr_src   (adr_src),
            .ir_write  (ir_write),
            .pc_write  (pc_write),
            .reg_write (reg_write),
            .alu_src_a (alu_src_a),
            .alu_src_b (alu_src_b),
            .alu_ctrl  (alu_ctrl),
            .imm_src   (imm_src),
            .result_src(result_src),
            .illegal   (illegal),
            .state     (state)
        );

        assign act[g] = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                         alu_src_b, alu_ctrl, imm_src, result_src, illegal, state};
    end

    obs_t  exp_q0[$];
    obs_t  exp_q1[$];
    item_t prog0[$];
    item_t prog1[$];

    item_t cur [2];
    bit    busy [2];
    bit    need_rst [2];
    int    kind [2];
    int    plan [2][6];
    int    plen [2];
    int    pidx [2];
    int    waited [2];
    int    age [2];
    int    trap_age [2];

    int checks = 0;
    int errors = 0;

    function automatic int classify(input logic [31:0] i, input bit mem_en);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
        if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
        if (op == 7'b0010011 && f3 == 3'd0) return K_ADDI;
        if (op == 7'b0000011 && f3 == 3'd2) return mem_en ? K_LW : K_ILL;
        if (op == 7'b0100011 && f3 == 3'd2) return mem_en ? K_SW : K_ILL;
        if (op == 7'b1100011 && f3 == 3'd0) return K_BEQ;
        if (op == 7'b1100011 && f3 == 3'd1) return K_BNE;
        if (op == 7'b1101111) return K_JAL;
        if (op == 7'b0110111) return K_LUI;
        return K_ILL;
    endfunction

    // Sequence of states an instruction class walks through, ignoring memory waits.
    task automatic load_plan(input int m);
        int p [6];
        int n;
        p = '{S_FETCH, S_DECODE, 0, 0, 0, 0};
        n = 3;
        case (kind[m])
            K_ADD, K_SUB: begin p[2] = S_EXECR;  p[3] = S_ALUWB;    n = 4; end
            K_ADDI:       begin p[2] = S_EXECI;  p[3] = S_ALUWB;    n = 4; end
            K_LW:         begin p[2] = S_MEMADR; p[3] = S_MEMREAD;  p[4] = S_MEMWB; n = 5; end
            K_SW:         begin p[2] = S_MEMADR; p[3] = S_MEMWRITE; n = 4; end
            K_BEQ, K_BNE: p[2] = S_BRANCH;
            K_JAL:        begin p[2] = S_JAL;    p[3] = S_ALUWB;    n = 4; end
            K_LUI:        p[2] = S_LUI;
            default:      p[2] = S_TRAP;
        endcase
        for (int k = 0; k < 6; k++) plan[m][k] = p[k];
        plen[m] = n;
        pidx[m] = 0;
    endtask

    function automatic obs_t exp_out(input int st, input int k, input bit mr, input bit z);
        obs_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            S_FETCH: begin
                e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                e.ir_write = mr; e.pc_write = mr;
            end
            S_DECODE: begin
                e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
                e.imm_src = (k == K_JAL) ? 3'd3 : 3'd2;
            end
            S_EXECR:    begin e.alu_src_a = 2'b10; e.alu_ctrl = (k == K_SUB) ? 3'd1 : 3'd0; end
            S_EXECI:    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            S_MEMADR: begin
                e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                e.imm_src = (k == K_SW) ? 3'd1 : 3'd0;
            end
            S_MEMREAD:  begin e.mem_req = 1'b1; e.adr_src = 1'b1; end
            S_MEMWB:    begin e.reg_write = 1'b1; e.result_src = 2'b01; end
            S_MEMWRITE: begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; end
            S_ALUWB:    e.reg_write = 1'b1;
            S_BRANCH: begin
                e.alu_src_a = 2'b10; e.alu_ctrl = 3'd1;
                e.pc_write = (k == K_BEQ) ? z : !z;
            end
            S_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            S_LUI:      begin e.imm_src = 3'd4; e.result_src = 2'b11; e.reg_write = 1'b1; end
            S_TRAP:     e.illegal = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic item_t rand_item(input int m);
        item_t       it;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [19:0] up;
        logic [2:0]  f3;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        up  = 20'($urandom);
        f3  = 3'($urandom_range(2, 7));
        case ($urandom_range(0, 11))
            0:  it.ins = {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            1:  it.ins = {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            2:  it.ins = {imm, rs1, 3'b000, rd, 7'b0010011};
            3:  it.ins = {imm, rs1, 3'b010, rd, 7'b0000011};
            4:  it.ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            5:  it.ins = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
            6:  it.ins = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
            7:  it.ins = {up, rd, 7'b1101111};
            8:  it.ins = {up, rd, 7'b0110111};
            9:  it.ins = {7'h01, rs2, rs1, 3'b000, rd, 7'b0110011};
            10: it.ins = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1100011};
            default: it.ins = $urandom;
        endcase
        if (m == 0) begin
            it.fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            it.mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
        end else begin
            it.fw = $urandom_range(0, 6);
            it.mw = $urandom_range(0, 6);
        end
        it.z      = 1'($urandom_range(0, 1));
        it.rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : -1;
        return it;
    endfunction

    task automatic push(input int m, input obs_t e);
        if (m == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // One clock cycle of stimulus for stream m, with the model's expected outputs for it.
    task automatic step(input int m);
        int st, want, tmo;
        bit mr, z, is_wait;
        tmo = (m == 0) ? T0 : 0;
        if (need_rst[m]) begin
            rst[m] = 1'b1;
            mem_ready[m] = 1'b1;
            push(m, '0);
            need_rst[m] = 1'b0;
            busy[m] = 1'b0;
            return;
        end
        if (!busy[m]) begin
            if (m == 0 && prog0.size() > 0)      cur[m] = prog0.pop_front();
            else if (m == 1 && prog1.size() > 0) cur[m] = prog1.pop_front();
            else                                 cur[m] = rand_item(m);
            instr[m]    = cur[m].ins;
            kind[m]     = classify(cur[m].ins, m == 0);
            load_plan(m);
            waited[m]   = 0;
            age[m]      = 0;
            trap_age[m] = 0;
            busy[m]     = 1'b1;
        end
        st = plan[m][pidx[m]];
        if (age[m] == cur[m].rst_at || (st == S_TRAP && trap_age[m] >= 3)) begin
            rst[m] = 1'b1;
            mem_ready[m] = 1'($urandom_range(0, 1));
            push(m, '0);
            busy[m] = 1'b0;
            return;
        end
        rst[m]  = 1'b0;
        is_wait = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);
        want    = (st == S_FETCH) ? cur[m].fw : cur[m].mw;
        mr      = is_wait ? (waited[m] >= want) : 1'($urandom_range(0, 1));
        z       = (kind[m] == K_BEQ || kind[m] == K_BNE) ? cur[m].z : 1'($urandom_range(0, 1));
        mem_ready[m] = mr;
        zero[m]      = z;
        push(m, exp_out(st, kind[m], mr, z));
        age[m]++;
        if (st == S_TRAP) begin
            trap_age[m]++;
        end else if (is_wait && !mr) begin
            if (tmo != 0 && waited[m] == tmo) begin
                plan[m][pidx[m]] = S_TRAP;
                waited[m] = 0;
            end else begin
                waited[m]++;
            end
        end else begin
            waited[m] = 0;
            pidx[m]++;
            if (pidx[m] == plen[m]) busy[m] = 1'b0;
        end
    endtask

    task automatic check(input int m, input obs_t exp, input obs_t got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stream%0d_outputs t=%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                     m, $time, got.state, got, exp.state, exp);
        end
    endtask

    // Monitor: compares whatever the DUTs present against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) check(0, exp_q0.pop_front(), act[0]);
            if (exp_q1.size() > 0) check(1, exp_q1.pop_front(), act[1]);
        end
    end

    initial begin
        instr[0] = 32'h0;
        instr[1] = 32'h0;
        need_rst = '{1'b1, 1'b1};
        busy     = '{1'b0, 1'b0};
        // Stream 0: memory enabled, 4-cycle timeout
        prog0.push_back(item_t'{32'h00500093, 0, 0, 1'b0, -1});  // ADDI x1,x0,5
        prog0.push_back(item_t'{32'hFE209EE3, 0, 0, 1'b0, -1});  // BNE, not equal -> taken
        prog0.push_back(item_t'{32'hFE209EE3, 0, 0, 1'b1, -1});  // BNE, equal -> not taken
        prog0.push_back(item_t'{32'h0000A183, 0, 3, 1'b0, -1});  // LW, 3 wait cycles
        prog0.push_back(item_t'{32'h00500093, 5, 0, 1'b0, -1});  // fetch never completes -> trap
        prog0.push_back(item_t'{32'h00500093, 4, 0, 1'b0, -1});  // ready on the timeout cycle
        prog0.push_back(item_t'{32'h0020A023, 0, 2, 1'b0, 4});   // SW, reset mid-MEMWRITE
        prog0.push_back(item_t'{32'h0000007F, 0, 0, 1'b0, -1});  // illegal opcode
        prog0.push_back(item_t'{32'h00500093, 0, 0, 1'b0, -1});
        // Stream 1: memory disabled, no timeout
        prog1.push_back(item_t'{32'h0020A023, 0, 0, 1'b0, -1});  // SW is illegal here
        prog1.push_back(item_t'{32'h0000A183, 0, 0, 1'b0, -1});  // LW is illegal here
        prog1.push_back(item_t'{32'h00500093, 9, 0, 1'b0, -1});  // long fetch wait, no trap
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            step(0);
            step(1);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
